// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester arbiter: sizes, FSM encoding and
// small index/vector helpers used by the controller.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Rotate a request vector right by sh positions so that bit p of the
  // result holds bit (p + sh) mod 4 of the input.
  function automatic logic [N_REQ-1:0] rotate_right(input logic [N_REQ-1:0] v,
                                                    input logic [IDX_W-1:0] sh);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[N_REQ-1:0];
  endfunction

endpackage

// File: rtl/prio_pick_4.sv
// Combinational highest-index-wins picker over a 4-bit eligible vector.
module prio_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Priority encode: bit 3 beats bit 2 beats bit 1 beats bit 0.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    casez (elig)
      4'b1???: begin valid = 1'b1; idx = 2'd3; end
      4'b01??: begin valid = 1'b1; idx = 2'd2; end
      4'b001?: begin valid = 1'b1; idx = 2'd1; end
      4'b0001: begin valid = 1'b1; idx = 2'd0; end
      default: begin valid = 1'b0; idx = 2'd0; end
    endcase
  end

endmodule

// File: rtl/arb_ctrl_4.sv
// Four-requester arbiter with fixed-priority or round-robin selection,
// bounded grant hold time, one-cycle turnaround gap and expiry fairness.
// All outputs come straight from flops; req never reaches gnt combinationally.
module arb_ctrl_4
  import arb_pkg::*;
#(
  parameter int unsigned RR_EN    = 0,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_v,
  output logic             timeout
);

  localparam logic       RR_MODE   = (RR_EN != 32'd0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);

  arb_state_e       state_r, state_s;
  logic [7:0]       hold_cnt_r, hold_cnt_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [N_REQ-1:0] excl_r, excl_s;

  logic [N_REQ-1:0] gnt_s;
  logic [IDX_W-1:0] gnt_id_s;
  logic             gnt_v_s;
  logic             timeout_s;

  logic [N_REQ-1:0] masked_s;
  logic [N_REQ-1:0] elig_s;
  logic [IDX_W-1:0] rot_ptr_s;
  logic [N_REQ-1:0] rot_elig_s;
  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             owner_req_s;

  // A requester that just timed out steps aside only if someone else wants
  // the bus; as the sole requester it competes normally.
  assign masked_s = req & ~excl_r;
  assign elig_s   = (masked_s != 4'b0000) ? masked_s : req;

  // Round-robin: rotating right by the last winner puts (ptr-1) at the top
  // of the picker, giving search order ptr-1, ptr-2, ptr-3, ptr.
  assign rot_ptr_s  = RR_MODE ? rr_ptr_r : 2'd0;
  assign rot_elig_s = rotate_right(elig_s, rot_ptr_s);

  prio_pick_4 u_pick (
    .elig  (rot_elig_s),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign win_idx_s   = pick_idx_s + rot_ptr_s;
  assign owner_req_s = req[gnt_id];

  // Next-state and next-output logic for the IDLE/GRANT/GAP sequence.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    rr_ptr_s   = rr_ptr_r;
    excl_s     = excl_r;
    gnt_s      = gnt;
    gnt_id_s   = gnt_id;
    gnt_v_s    = gnt_v;
    timeout_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s    = GRANT;
          hold_cnt_s = 8'd0;
          gnt_s      = idx_to_onehot(win_idx_s);
          gnt_id_s   = win_idx_s;
          gnt_v_s    = 1'b1;
          excl_s     = 4'b0000;
          rr_ptr_s   = RR_MODE ? win_idx_s : rr_ptr_r;
        end else begin
          gnt_s    = 4'b0000;
          gnt_id_s = 2'd0;
          gnt_v_s  = 1'b0;
        end
      end

      GRANT: begin
        if (!owner_req_s) begin
          // Release wins over a coincident expiry: no pulse, no exclusion.
          state_s    = GAP;
          hold_cnt_s = 8'd0;
          gnt_s      = 4'b0000;
          gnt_id_s   = 2'd0;
          gnt_v_s    = 1'b0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s    = GAP;
          hold_cnt_s = 8'd0;
          gnt_s      = 4'b0000;
          gnt_id_s   = 2'd0;
          gnt_v_s    = 1'b0;
          timeout_s  = 1'b1;
          excl_s     = idx_to_onehot(gnt_id);
        end else begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end
      end

      GAP: begin
        state_s  = IDLE;
        gnt_s    = 4'b0000;
        gnt_id_s = 2'd0;
        gnt_v_s  = 1'b0;
      end

      default: begin
        state_s    = IDLE;
        hold_cnt_s = 8'd0;
        gnt_s      = 4'b0000;
        gnt_id_s   = 2'd0;
        gnt_v_s    = 1'b0;
      end
    endcase
  end

  // State, counters, fairness bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      rr_ptr_r   <= 2'd0;
      excl_r     <= 4'b0000;
      gnt        <= 4'b0000;
      gnt_id     <= 2'd0;
      gnt_v      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      rr_ptr_r   <= rr_ptr_s;
      excl_r     <= excl_s;
      gnt        <= gnt_s;
      gnt_id     <= gnt_id_s;
      gnt_v      <= gnt_v_s;
      timeout    <= timeout_s;
    end
  end

endmodule

// File: tb/tb_arb_ctrl_4.sv
// Directed bench for arb_ctrl_4: fixed-priority (MAX_HOLD=8), round-robin
// (MAX_HOLD=8) and minimum-hold (MAX_HOLD=2) instances. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_arb_ctrl_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_f, req_r, req_m;

  logic [3:0] gnt_f, gnt_r, gnt_m;
  logic [1:0] gnt_id_f, gnt_id_r, gnt_id_m;
  logic       gnt_v_f, gnt_v_r, gnt_v_m;
  logic       timeout_f, timeout_r, timeout_m;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] TOUT = 8'h01;

  always #5 clk = ~clk;

  arb_ctrl_4 #(.RR_EN(0), .MAX_HOLD(8)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f),
    .gnt(gnt_f), .gnt_id(gnt_id_f), .gnt_v(gnt_v_f), .timeout(timeout_f)
  );

  arb_ctrl_4 #(.RR_EN(1), .MAX_HOLD(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r),
    .gnt(gnt_r), .gnt_id(gnt_id_r), .gnt_v(gnt_v_r), .timeout(timeout_r)
  );

  arb_ctrl_4 #(.RR_EN(0), .MAX_HOLD(2)) dut_min (
    .clk(clk), .rst_n(rst_n), .req(req_m),
    .gnt(gnt_m), .gnt_id(gnt_id_m), .gnt_v(gnt_v_m), .timeout(timeout_m)
  );

  wire [7:0] obs_f = {gnt_f, gnt_id_f, gnt_v_f, timeout_f};
  wire [7:0] obs_r = {gnt_r, gnt_id_r, gnt_v_r, timeout_r};
  wire [7:0] obs_m = {gnt_m, gnt_id_m, gnt_v_m, timeout_m};

  // Expected output bundle for an active grant to requester i.
  function automatic logic [7:0] gv(input int i);
    logic [1:0] id;
    logic [3:0] oh;
    id = i[1:0];
    oh = 4'b0001 << id;
    return {oh, id, 1'b1, 1'b0};
  endfunction

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got gnt=%b id=%0d v=%b to=%b, expected gnt=%b id=%0d v=%b to=%b",
               tag, obs[7:4], obs[3:2], obs[1], obs[0],
               exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int order [5] = '{3, 2, 1, 0, 3};

  initial begin
    rst_n = 1'b0;
    req_f = 4'b0000;
    req_r = 4'b0000;
    req_m = 4'b0000;
    step(2);
    check_vec("rst_fix", obs_f, NONE);
    check_vec("rst_rr", obs_r, NONE);
    check_vec("rst_min", obs_m, NONE);
    rst_n = 1'b1;
    step(1);
    check_vec("idle_noreq", obs_f, NONE);

    // Fixed priority: 0110 -> index 2 one cycle later, unaffected by req[3].
    req_f = 4'b0110;
    step(1);
    check_vec("fix_0110_lat", obs_f, gv(2));
    req_f = 4'b1110;
    step(1);
    check_vec("fix_hold_hi1", obs_f, gv(2));
    step(1);
    check_vec("fix_hold_hi2", obs_f, gv(2));
    req_f = 4'b0000;
    step(1);
    check_vec("fix_rel_gap", obs_f, NONE);
    step(1);
    check_vec("fix_rel_idle", obs_f, NONE);

    // Sole requester 3: 8 grant cycles, timeout gap, idle, re-grant.
    req_f = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_vec("exp_sole_hold", obs_f, gv(3));
    end
    step(1);
    check_vec("exp_sole_tout", obs_f, TOUT);
    step(1);
    check_vec("exp_sole_idle", obs_f, NONE);
    step(1);
    check_vec("exp_sole_regnt", obs_f, gv(3));
    req_f = 4'b0000;
    step(2);
    check_vec("exp_sole_done", obs_f, NONE);

    // 1001 held: 3 expires, 0 gets its turn, 0 expires, 3 again.
    req_f = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_vec("excl_g3", obs_f, gv(3));
    end
    step(1);
    check_vec("excl_tout3", obs_f, TOUT);
    step(1);
    check_vec("excl_idle3", obs_f, NONE);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_vec("excl_g0", obs_f, gv(0));
    end
    step(1);
    check_vec("excl_tout0", obs_f, TOUT);
    step(1);
    check_vec("excl_idle0", obs_f, NONE);
    step(1);
    check_vec("excl_back3", obs_f, gv(3));
    req_f = 4'b0000;
    step(2);

    // Release on the last allowed cycle: no timeout, no exclusion; requests
    // raised during GAP wait for IDLE.
    req_f = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_vec("rel_lim_g3", obs_f, gv(3));
    end
    req_f = 4'b0001;
    step(1);
    check_vec("rel_lim_gap", obs_f, NONE);
    req_f = 4'b1001;
    step(1);
    check_vec("gap_req_defer", obs_f, NONE);
    step(1);
    check_vec("rel_lim_noexcl", obs_f, gv(3));
    req_f = 4'b0000;
    step(2);

    // Reset during a grant to index 1 drops gnt at once.
    req_f = 4'b0010;
    step(1);
    check_vec("pre_rst_g1", obs_f, gv(1));
    step(1);
    rst_n = 1'b0;
    #1;
    check_vec("rst_async", obs_f, NONE);
    step(1);
    check_vec("rst_held", obs_f, NONE);
    rst_n = 1'b1;
    step(1);
    check_vec("post_rst_g1", obs_f, gv(1));
    req_f = 4'b0000;
    step(2);

    // Round robin with all four requesting; each drops 2 cycles in.
    req_r = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      check_vec("rr_order", obs_r, gv(order[k]));
      step(2);
      req_r[order[k]] = 1'b0;
      step(1);
      check_vec("rr_gap", obs_r, NONE);
      req_r[order[k]] = 1'b1;
      step(2);
    end
    req_r = 4'b0000;
    step(2);

    // Minimum hold of 2 cycles.
    req_m = 4'b0100;
    step(1);
    check_vec("min_g1", obs_m, gv(2));
    step(1);
    check_vec("min_g2", obs_m, gv(2));
    step(1);
    check_vec("min_tout", obs_m, TOUT);
    step(1);
    check_vec("min_idle", obs_m, NONE);
    step(1);
    check_vec("min_regnt", obs_m, gv(2));
    req_m = 4'b0000;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
